// File: rtl/life_pkg.sv
// Shared types for the Life memory arbiter: generation FSM states and the
// per-access tag that follows each read through the memory latency.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPUTE   = 2'd1,
        WAIT_SYNC = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic render_rd;
        logic upd_rd;
    } mem_tag_t;

endpackage : life_pkg

// File: rtl/life_mem_arbiter_tag_pipe.sv
// Fixed-depth shift register that carries an access tag alongside the memory
// read latency so returning data can be attributed to its requester.
module tag_pipe
    import life_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type tag_t = mem_tag_t
) (
    input  logic clk_in,
    input  logic rst_in,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule : tag_pipe

// File: rtl/life_mem_arbiter.sv
// Single-port cell memory arbiter: renderer has absolute priority, updater takes
// idle cycles via req/grant, and display/work banks swap only at frame sync.
module life_mem_arbiter
    import life_pkg::*;
#(
    parameter int ADDR_SIZE   = 16,
    parameter int LINE_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  render_valid_in,
    input  logic [ADDR_SIZE-2:0]  render_addr_in,
    output logic [LINE_WIDTH-1:0] render_data_out,
    input  logic                  upd_req_in,
    input  logic                  upd_we_in,
    input  logic [ADDR_SIZE-2:0]  upd_addr_in,
    input  logic [LINE_WIDTH-1:0] upd_wdata_in,
    output logic                  upd_gnt_out,
    output logic [LINE_WIDTH-1:0] upd_rdata_out,
    output logic                  upd_rvalid_out,
    output logic                  step_start_out,
    input  logic                  gen_done_in,
    input  logic                  frame_sync_in,
    input  logic                  run_in,
    output logic                  disp_bank_out,
    output logic [15:0]           gen_count_out,
    output logic [ADDR_SIZE-1:0]  mem_addr_out,
    output logic                  mem_we_out,
    output logic [LINE_WIDTH-1:0] mem_wdata_out,
    input  logic [LINE_WIDTH-1:0] mem_rdata_in
);

    localparam int TAG_DEPTH = 1 + MEM_LATENCY;

    arb_state_t            state_q, state_d;
    logic                  bank_q, bank_d;
    logic [15:0]           gen_q, gen_d;
    logic                  step_q, step_d;
    logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  gnt;
    mem_tag_t              tag_in, tag_tail;
    logic                  unused_render_tag;

    // Generation sequencer; frame_sync is only acted on in IDLE and WAIT_SYNC.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        gen_d   = gen_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_sync_in && run_in) begin
                    step_d  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (gen_done_in) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (frame_sync_in) begin
                    bank_d = ~bank_q;
                    gen_d  = gen_q + 16'd1;
                    if (run_in) begin
                        step_d  = 1'b1;
                        state_d = COMPUTE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt = upd_req_in & ~render_valid_in & (state_q == COMPUTE);

    // Reads always hit the displayed bank; updater writes go to the hidden one.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = upd_wdata_in;
        tag_in      = '0;
        if (render_valid_in) begin
            mem_addr_d       = {bank_q, render_addr_in};
            tag_in.render_rd = 1'b1;
        end else if (gnt) begin
            if (upd_we_in) begin
                mem_addr_d = {~bank_q, upd_addr_in};
                mem_we_d   = 1'b1;
            end else begin
                mem_addr_d    = {bank_q, upd_addr_in};
                tag_in.upd_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            gen_q       <= 16'd0;
            step_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            gen_q       <= gen_d;
            step_q      <= step_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    tag_pipe #(
        .DEPTH (TAG_DEPTH),
        .tag_t (mem_tag_t)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

    // Renderer latency is fixed, so its tag is carried only for symmetry.
    assign unused_render_tag = tag_tail.render_rd;

    assign upd_gnt_out     = gnt;
    assign render_data_out = mem_rdata_in;
    assign upd_rdata_out   = mem_rdata_in;
    assign upd_rvalid_out  = tag_tail.upd_rd;
    assign step_start_out  = step_q;
    assign disp_bank_out   = bank_q;
    assign gen_count_out   = gen_q;
    assign mem_addr_out    = mem_addr_q;
    assign mem_we_out      = mem_we_q;
    assign mem_wdata_out   = mem_wdata_q;

endmodule : life_mem_arbiter

// File: tb/tb_life_mem_arbiter.sv
// Bench for life_mem_arbiter with a 2-cycle-latency memory model and read-data scoreboards.
module tb_life_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        render_valid_in = 1'b0;
    logic [14:0] render_addr_in = '0;
    logic [7:0]  render_data_out;
    logic        upd_req_in = 1'b0;
    logic        upd_we_in = 1'b0;
    logic [14:0] upd_addr_in = '0;
    logic [7:0]  upd_wdata_in = '0;
    logic        upd_gnt_out;
    logic [7:0]  upd_rdata_out;
    logic        upd_rvalid_out;
    logic        step_start_out;
    logic        gen_done_in = 1'b0;
    logic        frame_sync_in = 1'b0;
    logic        run_in = 1'b0;
    logic        disp_bank_out;
    logic [15:0] gen_count_out;
    logic [15:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_wdata_out;
    logic [7:0]  mem_rdata_in;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;
    exp_t rd_q[$];
    exp_t up_q[$];
    exp_t mon_e;

    logic [7:0]  mem_model [0:65535];
    logic [15:0] rpipe0 = '0;
    logic [15:0] rpipe1 = '0;

    life_mem_arbiter dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .render_valid_in (render_valid_in),
        .render_addr_in  (render_addr_in),
        .render_data_out (render_data_out),
        .upd_req_in      (upd_req_in),
        .upd_we_in       (upd_we_in),
        .upd_addr_in     (upd_addr_in),
        .upd_wdata_in    (upd_wdata_in),
        .upd_gnt_out     (upd_gnt_out),
        .upd_rdata_out   (upd_rdata_out),
        .upd_rvalid_out  (upd_rvalid_out),
        .step_start_out  (step_start_out),
        .gen_done_in     (gen_done_in),
        .frame_sync_in   (frame_sync_in),
        .run_in          (run_in),
        .disp_bank_out   (disp_bank_out),
        .gen_count_out   (gen_count_out),
        .mem_addr_out    (mem_addr_out),
        .mem_we_out      (mem_we_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_rdata_in    (mem_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Memory sees the registered address one cycle after issue, data two cycles later.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (mem_we_out) mem_model[mem_addr_out] <= mem_wdata_out;
        rpipe0 <= mem_addr_out;
        rpipe1 <= rpipe0;
    end
    assign mem_rdata_in = mem_model[rpipe1];

    always @(negedge clk_in) begin
        if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            mon_e = rd_q.pop_front();
            checks++;
            if (mon_e.due != cyc || render_data_out !== mon_e.data) begin
                failures++;
                $display("FAIL render_data cyc=%0d due=%0d got=%02h exp=%02h", cyc, mon_e.due, render_data_out, mon_e.data);
            end
        end
        if (up_q.size() > 0 && up_q[0].due < cyc) begin
            mon_e = up_q.pop_front();
            checks++;
            failures++;
            $display("FAIL upd_rvalid_missing cyc=%0d due=%0d got=0 exp=1", cyc, mon_e.due);
        end
        if (upd_rvalid_out) begin
            checks++;
            if (up_q.size() == 0) begin
                failures++;
                $display("FAIL upd_rvalid_spurious cyc=%0d got=1 exp=0", cyc);
            end else begin
                mon_e = up_q.pop_front();
                if (mon_e.due != cyc || upd_rdata_out !== mon_e.data) begin
                    failures++;
                    $display("FAIL upd_rdata cyc=%0d due=%0d got=%02h exp=%02h", cyc, mon_e.due, upd_rdata_out, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b1;
        upd_req_in = 1'b1;
        #3;
        checks++; if (disp_bank_out !== 1'b0) begin failures++; $display("FAIL reset_bank got=%0h exp=0", disp_bank_out); end
        checks++; if (gen_count_out !== 16'd0) begin failures++; $display("FAIL reset_gen got=%0h exp=0", gen_count_out); end
        checks++; if (step_start_out !== 1'b0) begin failures++; $display("FAIL reset_step got=%0h exp=0", step_start_out); end
        checks++; if (upd_rvalid_out !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", upd_rvalid_out); end
        checks++; if (mem_we_out !== 1'b0 || mem_addr_out !== 16'h0 || mem_wdata_out !== 8'h0) begin
            failures++; $display("FAIL reset_mem we=%0h addr=%04h wdata=%02h exp=0/0000/00", mem_we_out, mem_addr_out, mem_wdata_out);
        end
        checks++; if (upd_gnt_out !== 1'b0) begin failures++; $display("FAIL reset_gnt_idle got=%0h exp=0", upd_gnt_out); end
        upd_req_in = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_start();
        run_in = 1'b1;
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
        checks++; if (step_start_out !== 1'b1) begin failures++; $display("FAIL start_step got=%0h exp=1", step_start_out); end
        checks++; if (disp_bank_out !== 1'b0) begin failures++; $display("FAIL start_bank got=%0h exp=0", disp_bank_out); end
        tick();
        checks++; if (step_start_out !== 1'b0) begin failures++; $display("FAIL start_step_width got=%0h exp=0", step_start_out); end
        upd_req_in = 1'b1;
        #1;
        checks++; if (upd_gnt_out !== 1'b1) begin failures++; $display("FAIL start_compute_gnt got=%0h exp=1", upd_gnt_out); end
        upd_req_in = 1'b0;
    endtask

    task automatic test_render_priority();
        tick();
        for (int i = 0; i < 4; i++) begin
            render_valid_in = 1'b1;
            render_addr_in = 15'h0010;
            upd_req_in = 1'b1;
            upd_we_in = 1'b0;
            #1;
            checks++; if (upd_gnt_out !== 1'b0) begin failures++; $display("FAIL prio_gnt i=%0d got=%0h exp=0", i, upd_gnt_out); end
            rd_q.push_back('{due: cyc + 3, data: init_val(16'h0010)});
            tick();
        end
        render_valid_in = 1'b0;
        upd_req_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_update_rw();
        upd_req_in = 1'b1;
        upd_we_in = 1'b1;
        upd_addr_in = 15'h0005;
        upd_wdata_in = 8'hA5;
        #1;
        checks++; if (upd_gnt_out !== 1'b1) begin failures++; $display("FAIL upd_wr_gnt got=%0h exp=1", upd_gnt_out); end
        tick();
        checks++; if (mem_we_out !== 1'b1 || mem_addr_out !== 16'h8005 || mem_wdata_out !== 8'hA5) begin
            failures++; $display("FAIL upd_wr_mem we=%0h addr=%04h wdata=%02h exp=1/8005/a5", mem_we_out, mem_addr_out, mem_wdata_out);
        end
        upd_we_in = 1'b0;
        #1;
        checks++; if (upd_gnt_out !== 1'b1) begin failures++; $display("FAIL upd_rd_gnt got=%0h exp=1", upd_gnt_out); end
        up_q.push_back('{due: cyc + 3, data: init_val(16'h0005)});
        tick();
        upd_req_in = 1'b0;
        checks++; if (mem_we_out !== 1'b0 || mem_addr_out !== 16'h0005) begin
            failures++; $display("FAIL upd_rd_mem we=%0h addr=%04h exp=0/0005", mem_we_out, mem_addr_out);
        end
        tick();
        checks++; if (mem_we_out !== 1'b0 || mem_addr_out !== 16'h0005) begin
            failures++; $display("FAIL idle_hold we=%0h addr=%04h exp=0/0005", mem_we_out, mem_addr_out);
        end
        repeat (4) tick();
    endtask

    task automatic test_done_sync_swap();
        gen_done_in = 1'b1;
        frame_sync_in = 1'b1;
        tick();
        gen_done_in = 1'b0;
        frame_sync_in = 1'b0;
        checks++; if (disp_bank_out !== 1'b0 || gen_count_out !== 16'd0 || step_start_out !== 1'b0) begin
            failures++; $display("FAIL done_sync_same bank=%0h gen=%0d step=%0h exp=0/0/0", disp_bank_out, gen_count_out, step_start_out);
        end
        upd_req_in = 1'b1;
        #1;
        checks++; if (upd_gnt_out !== 1'b0) begin failures++; $display("FAIL wait_sync_gnt got=%0h exp=0", upd_gnt_out); end
        upd_req_in = 1'b0;
        tick();
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
        checks++; if (disp_bank_out !== 1'b1 || gen_count_out !== 16'd1 || step_start_out !== 1'b1) begin
            failures++; $display("FAIL swap bank=%0h gen=%0d step=%0h exp=1/1/1", disp_bank_out, gen_count_out, step_start_out);
        end
        tick();
        checks++; if (step_start_out !== 1'b0) begin failures++; $display("FAIL swap_step_width got=%0h exp=0", step_start_out); end
        render_valid_in = 1'b1;
        render_addr_in = 15'h0005;
        rd_q.push_back('{due: cyc + 3, data: 8'hA5});
        tick();
        render_valid_in = 1'b0;
        checks++; if (mem_addr_out !== 16'h8005) begin failures++; $display("FAIL swap_render_addr got=%04h exp=8005", mem_addr_out); end
        repeat (4) tick();
    endtask

    task automatic test_pause();
        gen_done_in = 1'b1;
        tick();
        gen_done_in = 1'b0;
        run_in = 1'b0;
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
        checks++; if (disp_bank_out !== 1'b0 || gen_count_out !== 16'd2 || step_start_out !== 1'b0) begin
            failures++; $display("FAIL pause_swap bank=%0h gen=%0d step=%0h exp=0/2/0", disp_bank_out, gen_count_out, step_start_out);
        end
        tick();
        upd_req_in = 1'b1;
        #1;
        checks++; if (upd_gnt_out !== 1'b0) begin failures++; $display("FAIL pause_idle_gnt got=%0h exp=0", upd_gnt_out); end
        upd_req_in = 1'b0;
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
        checks++; if (step_start_out !== 1'b0 || disp_bank_out !== 1'b0 || gen_count_out !== 16'd2) begin
            failures++; $display("FAIL pause_hold step=%0h bank=%0h gen=%0d exp=0/0/2", step_start_out, disp_bank_out, gen_count_out);
        end
    endtask

    task automatic test_reset_inflight();
        run_in = 1'b1;
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
        checks++; if (step_start_out !== 1'b1 || disp_bank_out !== 1'b0 || gen_count_out !== 16'd2) begin
            failures++; $display("FAIL restart step=%0h bank=%0h gen=%0d exp=1/0/2", step_start_out, disp_bank_out, gen_count_out);
        end
        upd_req_in = 1'b1;
        upd_we_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            upd_addr_in = 15'(3 + i);
            #1;
            checks++; if (upd_gnt_out !== 1'b1) begin failures++; $display("FAIL inflight_gnt i=%0d got=%0h exp=1", i, upd_gnt_out); end
            tick();
        end
        upd_req_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        checks++; if (upd_rvalid_out !== 1'b0 || mem_addr_out !== 16'h0 || mem_we_out !== 1'b0 || mem_wdata_out !== 8'h0) begin
            failures++; $display("FAIL async_rst_mem rvalid=%0h addr=%04h we=%0h wdata=%02h exp=0", upd_rvalid_out, mem_addr_out, mem_we_out, mem_wdata_out);
        end
        checks++; if (disp_bank_out !== 1'b0 || gen_count_out !== 16'd0 || step_start_out !== 1'b0) begin
            failures++; $display("FAIL async_rst_fsm bank=%0h gen=%0d step=%0h exp=0/0/0", disp_bank_out, gen_count_out, step_start_out);
        end
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (upd_rvalid_out !== 1'b0) begin failures++; $display("FAIL rst_drop_rvalid i=%0d got=1 exp=0", i); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = init_val(16'(i));
        test_reset();
        test_start();
        test_render_priority();
        test_update_rw();
        test_done_sync_swap();
        test_pause();
        test_reset_inflight();
        repeat (4) tick();
        checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL render_pending got=%0d exp=0", rd_q.size()); end
        checks++; if (up_q.size() != 0) begin failures++; $display("FAIL upd_pending got=%0d exp=0", up_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_life_mem_arbiter
